psm_setpoint_sequencer: RTL and testbench

//  Start/stop and slew-rate sequencer that drives the PSM modulator's configuration inputs. It soft-starts
//  SPS/DPS phase shifts from 0 to target, stepping only on carrier period boundaries, and latches frequency and

---
 rtl/psm_setpoint_sequencer.sv | 156 +++++++++++++++
 tb/tb_psm_setpoint_sequencer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/psm_setpoint_sequencer.sv
// rtl/psm_setpoint_sequencer.sv - soft-start/stop slew sequencer feeding the PSM modulator configuration
module psm_setpoint_sequencer #(
    parameter int BITS_DATA   = 16,
    parameter int STEP        = 16,
    parameter int ARM_PERIODS = 4,
    parameter int WDOG_CYCLES = 65535
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 iEnable,
    input  logic                 iFault,
    input  logic                 iClear,
    input  logic                 iPeriodStart,
    input  logic [BITS_DATA-1:0] iSPS_target,
    input  logic                 iSPS_sign,
    input  logic [BITS_DATA-1:0] iDPS_target,
    input  logic                 iDPS_sign,
    input  logic                 iN,
    input  logic [BITS_DATA-1:0] iFREQUENCY,
    input  logic [7:0]           iDEADTIME,
    output logic [BITS_DATA-1:0] oSPS_value,
    output logic                 oSPS_sign,
    output logic [BITS_DATA-1:0] oDPS_value,
    output logic                 oDPS_sign,
    output logic                 oN,
    output logic [BITS_DATA-1:0] oFREQUENCY,
    output logic [7:0]           oDEADTIME,
    output logic                 oPSM_RST,
    output logic                 oAtTarget,
    output logic [2:0]           oState,
    output logic [1:0]           oFaultCode
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_RUN   = 3'd2,
        S_STOP  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    localparam int ARM_W  = $clog2(ARM_PERIODS + 1);
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
    localparam logic signed [BITS_DATA+1:0] STEP_P    = (BITS_DATA+2)'(STEP);
    localparam logic [ARM_W-1:0]            ARM_LAST  = ARM_W'(ARM_PERIODS - 1);
    localparam logic [WDOG_W-1:0]           WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

    state_t state, state_nxt;
    logic signed [BITS_DATA:0] sps_cur, dps_cur, sps_tgt, dps_tgt, sps_nxt, dps_nxt;
    logic [BITS_DATA-1:0] freq_reg;
    logic [7:0]           dt_reg;
    logic [1:0]           fault_code;
    logic [ARM_W-1:0]     arm_cnt;
    logic [WDOG_W-1:0]    wdog_cnt;
    logic                 n_reg, en_q, active, start_ok, wdog_trip;

    // Signed setpoint with magnitude limited to the latched carrier period.
    function automatic logic signed [BITS_DATA:0] clamp_target(
        input logic [BITS_DATA-1:0] mag, input logic sgn, input logic [BITS_DATA-1:0] lim);
        logic [BITS_DATA:0] m;
        m = {1'b0, (mag > lim) ? lim : mag};
        return sgn ? $signed(m) : -$signed(m);
    endfunction

    // One slew step; passing through zero is just ordinary signed arithmetic.
    function automatic logic signed [BITS_DATA:0] step_toward(
        input logic signed [BITS_DATA:0] cur, input logic signed [BITS_DATA:0] tgt);
        logic signed [BITS_DATA+1:0] diff, sum;
        diff = {tgt[BITS_DATA], tgt} - {cur[BITS_DATA], cur};
        if (diff > STEP_P)       diff = STEP_P;
        else if (diff < -STEP_P) diff = -STEP_P;
        sum = {cur[BITS_DATA], cur} + diff;
        return (BITS_DATA+1)'(sum);
    endfunction

    always_comb begin
        sps_tgt   = clamp_target(iSPS_target, iSPS_sign, freq_reg);
        dps_tgt   = clamp_target(iDPS_target, iDPS_sign, freq_reg);
        sps_nxt   = step_toward(sps_cur, iEnable ? sps_tgt : '0);
        dps_nxt   = step_toward(dps_cur, iEnable ? dps_tgt : '0);
        active    = (state == S_ARM) || (state == S_RUN) || (state == S_STOP);
        start_ok  = iEnable && !en_q && !iFault && (iFREQUENCY >= BITS_DATA'(2));
        wdog_trip = active && !iPeriodStart && (wdog_cnt == WDOG_LAST);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_ok) state_nxt = S_ARM;
            S_ARM:   if (!iEnable) state_nxt = S_IDLE;
                     else if (iPeriodStart && arm_cnt == ARM_LAST) state_nxt = S_RUN;
            S_RUN:   if (!iEnable) state_nxt = S_STOP;
            S_STOP:  if (iEnable) state_nxt = S_RUN;
                     else if (iPeriodStart && sps_nxt == '0 && dps_nxt == '0) state_nxt = S_IDLE;
            S_FAULT: if (iClear && !iFault) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (active && (iFault || wdog_trip)) state_nxt = S_FAULT;
    end

    always_comb begin
        oPSM_RST  = (state == S_IDLE) || (state == S_FAULT);
        oState    = state;
        oAtTarget = (state == S_RUN) && (sps_cur == sps_tgt) && (dps_cur == dps_tgt);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sps_cur    <= '0;
            dps_cur    <= '0;
            n_reg      <= 1'b0;
            freq_reg   <= '0;
            dt_reg     <= '0;
            fault_code <= 2'b00;
            arm_cnt    <= '0;
            wdog_cnt   <= '0;
            en_q       <= 1'b0;
        end else begin
            en_q <= iEnable;
            if (state == S_IDLE && state_nxt == S_ARM) begin
                freq_reg <= iFREQUENCY;
                dt_reg   <= iDEADTIME;
            end
            if (state_nxt != S_RUN && state_nxt != S_STOP) begin
                sps_cur <= '0;
                dps_cur <= '0;
            end else if (iPeriodStart && (state == S_RUN || state == S_STOP)) begin
                sps_cur <= sps_nxt;
                dps_cur <= dps_nxt;
            end
            // Bridge select only changes while no DPS shift is being applied.
            if (active && iPeriodStart && dps_cur == '0) n_reg <= iN;
            if (state != S_ARM)    arm_cnt <= '0;
            else if (iPeriodStart) arm_cnt <= arm_cnt + 1'b1;
            if (!active || iPeriodStart) wdog_cnt <= '0;
            else if (!wdog_trip)         wdog_cnt <= wdog_cnt + 1'b1;
            if (state != S_FAULT && state_nxt == S_FAULT)      fault_code <= iFault ? 2'b01 : 2'b10;
            else if (state == S_FAULT && state_nxt != S_FAULT) fault_code <= 2'b00;
        end
    end

    assign oSPS_sign  = ~sps_cur[BITS_DATA];
    assign oDPS_sign  = ~dps_cur[BITS_DATA];
    assign oSPS_value = sps_cur[BITS_DATA] ? (~sps_cur[BITS_DATA-1:0] + 1'b1) : sps_cur[BITS_DATA-1:0];
    assign oDPS_value = dps_cur[BITS_DATA] ? (~dps_cur[BITS_DATA-1:0] + 1'b1) : dps_cur[BITS_DATA-1:0];
    assign oN         = n_reg;
    assign oFREQUENCY = freq_reg;
    assign oDEADTIME  = dt_reg;
    assign oFaultCode = fault_code;

endmodule

// File: tb/tb_psm_setpoint_sequencer.sv
// tb/tb_psm_setpoint_sequencer.sv - directed self-checking bench for psm_setpoint_sequencer
module tb_psm_setpoint_sequencer;

    localparam int WDOG = 300;

    logic        CLK = 1'b0, RST_N = 1'b0;
    logic        iEnable = 1'b0, iFault = 1'b0, iClear = 1'b0, iPeriodStart = 1'b0;
    logic [15:0] iSPS_target = '0, iDPS_target = '0, iFREQUENCY = '0;
    logic        iSPS_sign = 1'b1, iDPS_sign = 1'b1, iN = 1'b0;
    logic [7:0]  iDEADTIME = '0;
    logic [15:0] oSPS_value, oDPS_value, oFREQUENCY;
    logic        oSPS_sign, oDPS_sign, oN, oPSM_RST, oAtTarget;
    logic [7:0]  oDEADTIME;
    logic [2:0]  oState;
    logic [1:0]  oFaultCode;
    int checks = 0, errors = 0;

    psm_setpoint_sequencer #(.BITS_DATA(16), .STEP(16), .ARM_PERIODS(4), .WDOG_CYCLES(WDOG)) dut (
        .CLK(CLK), .RST_N(RST_N), .iEnable(iEnable), .iFault(iFault), .iClear(iClear),
        .iPeriodStart(iPeriodStart), .iSPS_target(iSPS_target), .iSPS_sign(iSPS_sign),
        .iDPS_target(iDPS_target), .iDPS_sign(iDPS_sign), .iN(iN), .iFREQUENCY(iFREQUENCY),
        .iDEADTIME(iDEADTIME), .oSPS_value(oSPS_value), .oSPS_sign(oSPS_sign),
        .oDPS_value(oDPS_value), .oDPS_sign(oDPS_sign), .oN(oN), .oFREQUENCY(oFREQUENCY),
        .oDEADTIME(oDEADTIME), .oPSM_RST(oPSM_RST), .oAtTarget(oAtTarget), .oState(oState),
        .oFaultCode(oFaultCode));

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic boundary();
        iPeriodStart = 1'b1;
        tick();
        iPeriodStart = 1'b0;
        repeat (3) tick();
    endtask

    task automatic arm_to_run();
        for (int i = 0; i < 4; i++) begin
            boundary();
            checks++; if (oSPS_value !== 16'd0) begin errors++; $display("FAIL arm_zero[%0d]: got %0d expected 0", i, oSPS_value); end
        end
    endtask

    task automatic test_reset();
        repeat (2) tick();
        checks++; if (oState !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", oState); end
        checks++; if (oPSM_RST !== 1'b1) begin errors++; $display("FAIL reset_psm_rst: got %0b expected 1", oPSM_RST); end
        checks++; if ({oSPS_value, oDPS_value, oFREQUENCY, oDEADTIME, oN, oAtTarget, oFaultCode} !== '0)
            begin errors++; $display("FAIL reset_values: got %0h expected 0", {oSPS_value, oDPS_value, oFREQUENCY, oDEADTIME, oN, oAtTarget, oFaultCode}); end
        RST_N = 1'b1;
        tick();
    endtask

    task automatic test_start();
        int exp_sps [3] = '{16, 32, 40};
        iFREQUENCY = 16'd1000; iDEADTIME = 8'd25; iSPS_target = 16'd40; iSPS_sign = 1'b1;
        iEnable = 1'b1;
        tick();
        checks++; if (oState !== 3'd1) begin errors++; $display("FAIL start_arm: got %0d expected 1", oState); end
        checks++; if (oPSM_RST !== 1'b0) begin errors++; $display("FAIL start_psm_rst: got %0b expected 0", oPSM_RST); end
        checks++; if (oFREQUENCY !== 16'd1000 || oDEADTIME !== 8'd25) begin errors++; $display("FAIL start_latch: got %0d/%0d expected 1000/25", oFREQUENCY, oDEADTIME); end
        iFREQUENCY = 16'd500; iDEADTIME = 8'd7;
        repeat (3) boundary();
        checks++; if (oState !== 3'd1) begin errors++; $display("FAIL start_arm_hold: got %0d expected 1", oState); end
        boundary();
        checks++; if (oState !== 3'd2) begin errors++; $display("FAIL start_run: got %0d expected 2", oState); end
        checks++; if (oSPS_value !== 16'd0) begin errors++; $display("FAIL start_run_zero: got %0d expected 0", oSPS_value); end
        for (int i = 0; i < 3; i++) begin
            boundary();
            checks++; if (oSPS_value !== 16'(exp_sps[i]) || oSPS_sign !== 1'b1) begin errors++; $display("FAIL start_ramp[%0d]: got %0d sign %0b expected %0d sign 1", i, oSPS_value, oSPS_sign, exp_sps[i]); end
            checks++; if (oAtTarget !== (i == 2)) begin errors++; $display("FAIL start_at_target[%0d]: got %0b expected %0b", i, oAtTarget, (i == 2)); end
        end
        checks++; if (oFREQUENCY !== 16'd1000 || oDEADTIME !== 8'd25) begin errors++; $display("FAIL start_latch_hold: got %0d/%0d expected 1000/25", oFREQUENCY, oDEADTIME); end
    endtask

    task automatic test_sign_cross();
        int exp_val [7] = '{24, 8, 8, 24, 30, 14, 0};
        logic exp_sgn [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 7; i++) begin
            if (i == 0) begin iSPS_target = 16'd8;  iSPS_sign = 1'b1; end
            if (i == 2) begin iSPS_target = 16'd30; iSPS_sign = 1'b0; end
            if (i == 5) begin iSPS_target = 16'd0;  iSPS_sign = 1'b0; end
            boundary();
            checks++; if (oSPS_value !== 16'(exp_val[i]) || oSPS_sign !== exp_sgn[i])
                begin errors++; $display("FAIL sign_cross[%0d]: got %0d sign %0b expected %0d sign %0b", i, oSPS_value, oSPS_sign, exp_val[i], exp_sgn[i]); end
        end
    endtask

    task automatic test_clamp_n();
        iDPS_target = 16'd1500; iDPS_sign = 1'b1; iN = 1'b0;
        boundary();
        checks++; if (oDPS_value !== 16'd16) begin errors++; $display("FAIL clamp_first: got %0d expected 16", oDPS_value); end
        iN = 1'b1;
        repeat (62) boundary();
        checks++; if (oDPS_value !== 16'd1000) begin errors++; $display("FAIL clamp_settle: got %0d expected 1000", oDPS_value); end
        boundary();
        checks++; if (oDPS_value !== 16'd1000 || oAtTarget !== 1'b1) begin errors++; $display("FAIL clamp_hold: got %0d at %0b expected 1000 at 1", oDPS_value, oAtTarget); end
        checks++; if (oN !== 1'b0) begin errors++; $display("FAIL n_held: got %0b expected 0", oN); end
        iDPS_target = 16'd0;
        repeat (63) boundary();
        checks++; if (oDPS_value !== 16'd0 || oDPS_sign !== 1'b1 || oN !== 1'b0) begin errors++; $display("FAIL dps_zero: got %0d sign %0b n %0b expected 0 sign 1 n 0", oDPS_value, oDPS_sign, oN); end
        boundary();
        checks++; if (oN !== 1'b1) begin errors++; $display("FAIL n_commit: got %0b expected 1", oN); end
    endtask

    task automatic test_stop();
        iSPS_target = 16'd40; iSPS_sign = 1'b1;
        repeat (3) boundary();
        checks++; if (oSPS_value !== 16'd40) begin errors++; $display("FAIL stop_pre: got %0d expected 40", oSPS_value); end
        iEnable = 1'b0;
        tick();
        checks++; if (oState !== 3'd3) begin errors++; $display("FAIL stop_state: got %0d expected 3", oState); end
        boundary();
        checks++; if (oSPS_value !== 16'd24) begin errors++; $display("FAIL stop_24: got %0d expected 24", oSPS_value); end
        boundary();
        checks++; if (oSPS_value !== 16'd8 || oState !== 3'd3) begin errors++; $display("FAIL stop_8: got %0d state %0d expected 8 state 3", oSPS_value, oState); end
        iPeriodStart = 1'b1;
        tick();
        iPeriodStart = 1'b0;
        checks++; if (oSPS_value !== 16'd0 || oState !== 3'd0 || oPSM_RST !== 1'b1) begin errors++; $display("FAIL stop_idle: got %0d state %0d rst %0b expected 0 state 0 rst 1", oSPS_value, oState, oPSM_RST); end
    endtask

    task automatic test_reject();
        iFREQUENCY = 16'd1; iEnable = 1'b1;
        tick();
        checks++; if (oState !== 3'd0 || oFREQUENCY !== 16'd1000) begin errors++; $display("FAIL reject: got state %0d freq %0d expected state 0 freq 1000", oState, oFREQUENCY); end
        iEnable = 1'b0;
        tick();
    endtask

    task automatic test_faults();
        iFREQUENCY = 16'd1000; iEnable = 1'b1;
        tick();
        arm_to_run();
        boundary();
        checks++; if (oSPS_value !== 16'd16 || oState !== 3'd2) begin errors++; $display("FAIL fault_pre: got %0d state %0d expected 16 state 2", oSPS_value, oState); end
        iFault = 1'b1;
        tick();
        checks++; if (oState !== 3'd4 || oFaultCode !== 2'b01 || oPSM_RST !== 1'b1 || oSPS_value !== 16'd0)
            begin errors++; $display("FAIL fault_ext: got state %0d code %0d rst %0b sps %0d expected 4 1 1 0", oState, oFaultCode, oPSM_RST, oSPS_value); end
        iClear = 1'b1; tick(); iClear = 1'b0;
        checks++; if (oState !== 3'd4) begin errors++; $display("FAIL fault_clear_ignored: got %0d expected 4", oState); end
        iFault = 1'b0; tick();
        checks++; if (oState !== 3'd4 || oFaultCode !== 2'b01) begin errors++; $display("FAIL fault_code_hold: got state %0d code %0d expected 4 1", oState, oFaultCode); end
        iClear = 1'b1; tick(); iClear = 1'b0;
        checks++; if (oState !== 3'd0 || oFaultCode !== 2'b00) begin errors++; $display("FAIL fault_exit: got state %0d code %0d expected 0 0", oState, oFaultCode); end
        repeat (3) tick();
        checks++; if (oState !== 3'd0) begin errors++; $display("FAIL no_autorestart: got %0d expected 0", oState); end
        iEnable = 1'b0; tick(); iEnable = 1'b1; tick();
        checks++; if (oState !== 3'd1) begin errors++; $display("FAIL wdog_arm: got %0d expected 1", oState); end
        repeat (WDOG - 1) tick();
        checks++; if (oState !== 3'd1) begin errors++; $display("FAIL wdog_early: got %0d expected 1", oState); end
        tick();
        checks++; if (oState !== 3'd4 || oFaultCode !== 2'b10) begin errors++; $display("FAIL wdog_trip: got state %0d code %0d expected 4 2", oState, oFaultCode); end
        iClear = 1'b1; tick(); iClear = 1'b0;
        checks++; if (oState !== 3'd0 || oFaultCode !== 2'b00) begin errors++; $display("FAIL wdog_exit: got state %0d code %0d expected 0 0", oState, oFaultCode); end
        iEnable = 1'b0; tick();
    endtask

    task automatic test_async_reset();
        iEnable = 1'b1;
        tick();
        arm_to_run();
        boundary();
        checks++; if (oSPS_value !== 16'd16) begin errors++; $display("FAIL areset_pre: got %0d expected 16", oSPS_value); end
        #2 RST_N = 1'b0;
        #1;
        checks++; if (oState !== 3'd0 || oPSM_RST !== 1'b1 || oSPS_value !== 16'd0 || oFREQUENCY !== 16'd0 || oDEADTIME !== 8'd0)
            begin errors++; $display("FAIL areset: got state %0d rst %0b sps %0d freq %0d dt %0d expected 0 1 0 0 0", oState, oPSM_RST, oSPS_value, oFREQUENCY, oDEADTIME); end
        iEnable = 1'b0;
        tick();
        RST_N = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_start();
        test_sign_cross();
        test_clamp_n();
        test_stop();
        test_reject();
        test_faults();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
